// File: rtl/serial_word_feeder.sv
// -----------------------------------------------------------------------------
// serial_word_feeder
//
// Parallel-to-serial front end for the bit-serial sequence detector. Accepts a
// WIDTH-bit word over a valid/ready handshake and plays it out one bit per
// clock on sequence_out, optionally followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clock         rising-edge clock for all state
//   reset         synchronous reset, active low (0 = reset)
//   word_in       parallel word, sampled only on a transfer edge
//   word_valid    word_in is valid
//   word_ready    feeder accepts word_in this cycle (from state only)
//   sequence_out  serial bit stream (IDLE_LEVEL when no word bit is sent)
//   bit_valid     sequence_out carries a word bit
//   frame_start   high together with the first bit of every word
//   busy          feeder is not idle
//   words_sent    wrapping count of completely transmitted words
// -----------------------------------------------------------------------------
module serial_word_feeder #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0,
    parameter int IDLE_LEVEL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic [15:0]      words_sent
);

    // Refuse to build with parameters outside the supported range.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_word_feeder: WIDTH must be in 2..32");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("serial_word_feeder: GAP_CYCLES must be in 0..15");
    end
    if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_order
        $error("serial_word_feeder: MSB_FIRST must be 0 or 1");
    end
    if (IDLE_LEVEL < 0 || IDLE_LEVEL > 1) begin : g_bad_idle
        $error("serial_word_feeder: IDLE_LEVEL must be 0 or 1");
    end

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]     GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic           IDLE_BIT = (IDLE_LEVEL != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;
    logic             take;

    // Bit at the send end of a word.
    function automatic logic send_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Move the next bit to the send end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // Ready depends on state only, so a source may safely wait on it before
    // raising word_valid. With no gap the last bit cycle can accept the next
    // word, which gives back-to-back words without a bubble.
    assign word_ready = reset &&
                        ((state == IDLE) ||
                         (state == SHIFT && bit_cnt == LAST_BIT && GAP_CYCLES == 0));
    assign take = word_valid && word_ready;
    assign busy = (state != IDLE);

    // The register holds the bits still to come; the bit currently on the
    // line already sits in sequence_out, so a loaded word is pre-advanced.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            sequence_out <= IDLE_BIT;
            bit_valid    <= 1'b0;
            frame_start  <= 1'b0;
            words_sent   <= 16'd0;
            bit_cnt      <= '0;
            gap_cnt      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state        <= SHIFT;
                        shreg        <= advance(word_in);
                        sequence_out <= send_bit(word_in);
                        bit_valid    <= 1'b1;
                        frame_start  <= 1'b1;
                        bit_cnt      <= '0;
                    end else begin
                        sequence_out <= IDLE_BIT;
                        bit_valid    <= 1'b0;
                        frame_start  <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        words_sent <= words_sent + 16'd1;
                        if (GAP_CYCLES > 0) begin
                            state        <= GAP;
                            gap_cnt      <= 4'd0;
                            sequence_out <= IDLE_BIT;
                            bit_valid    <= 1'b0;
                            frame_start  <= 1'b0;
                        end else if (take) begin
                            shreg        <= advance(word_in);
                            sequence_out <= send_bit(word_in);
                            bit_valid    <= 1'b1;
                            frame_start  <= 1'b1;
                            bit_cnt      <= '0;
                        end else begin
                            state        <= IDLE;
                            sequence_out <= IDLE_BIT;
                            bit_valid    <= 1'b0;
                            frame_start  <= 1'b0;
                        end
                    end else begin
                        shreg        <= advance(shreg);
                        sequence_out <= send_bit(shreg);
                        frame_start  <= 1'b0;
                        bit_cnt      <= bit_cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    // Line outputs were already parked at idle on entry.
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    sequence_out <= IDLE_BIT;
                    bit_valid    <= 1'b0;
                    frame_start  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for serial_word_feeder. Three instances with different parameter
// sets share one clock and reset. A reference model tracks, per instance, the
// word being sent, how many of its bits remain, how many gap cycles remain and
// the sent-word count, and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_serial_word_feeder;

    localparam int N = 3;
    localparam int W_A    [N] = '{4, 4, 2};
    localparam int MSB_A  [N] = '{1, 0, 1};
    localparam int GAP_A  [N] = '{0, 2, 0};
    localparam int IDLE_A [N] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        reset;
    logic        vld  [N];
    logic [31:0] wd   [N];
    logic        rdy  [N];
    logic        seq  [N];
    logic        bv   [N];
    logic        fs   [N];
    logic        busy [N];
    logic [15:0] ws   [N];

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_LEVEL(0)) u0 (
        .clock(clk), .reset(reset), .word_in(wd[0][3:0]), .word_valid(vld[0]),
        .word_ready(rdy[0]), .sequence_out(seq[0]), .bit_valid(bv[0]),
        .frame_start(fs[0]), .busy(busy[0]), .words_sent(ws[0]));

    serial_word_feeder #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(2), .IDLE_LEVEL(1)) u1 (
        .clock(clk), .reset(reset), .word_in(wd[1][3:0]), .word_valid(vld[1]),
        .word_ready(rdy[1]), .sequence_out(seq[1]), .bit_valid(bv[1]),
        .frame_start(fs[1]), .busy(busy[1]), .words_sent(ws[1]));

    serial_word_feeder #(.WIDTH(2), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_LEVEL(0)) u2 (
        .clock(clk), .reset(reset), .word_in(wd[2][1:0]), .word_valid(vld[2]),
        .word_ready(rdy[2]), .sequence_out(seq[2]), .bit_valid(bv[2]),
        .frame_start(fs[2]), .busy(busy[2]), .words_sent(ws[2]));

    // Reference model state
    int          m_left [N];
    int          m_gap  [N];
    logic [31:0] m_word [N];
    logic [15:0] m_cnt  [N];
    bit          m_acc  [N];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] cap0, cap1;
    int          fs_prev1, fs_last1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready(input int i);
        return (reset === 1'b1) &&
               ((m_left[i] == 0 && m_gap[i] == 0) || (m_left[i] == 1 && GAP_A[i] == 0));
    endfunction

    function automatic logic m_seq(input int i);
        int k;
        if (m_left[i] == 0) return (IDLE_A[i] != 0);
        k = W_A[i] - m_left[i];
        return (MSB_A[i] != 0) ? m_word[i][W_A[i] - 1 - k] : m_word[i][k];
    endfunction

    // One clock: compare outputs mid-cycle, advance the model using the inputs
    // the coming edge will see, then return just after that edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("u%0d_seq", i),   {31'd0, seq[i]},  {31'd0, m_seq(i)});
            check_val($sformatf("u%0d_bv", i),    {31'd0, bv[i]},   {31'd0, m_left[i] > 0});
            check_val($sformatf("u%0d_fs", i),    {31'd0, fs[i]},   {31'd0, m_left[i] == W_A[i]});
            check_val($sformatf("u%0d_busy", i),  {31'd0, busy[i]}, {31'd0, (m_left[i] > 0) || (m_gap[i] > 0)});
            check_val($sformatf("u%0d_ready", i), {31'd0, rdy[i]},  {31'd0, m_ready(i)});
            check_val($sformatf("u%0d_ws", i),    {16'd0, ws[i]},   {16'd0, m_cnt[i]});
        end
        if (bv[0] === 1'b1) cap0 = {cap0[30:0], seq[0]};
        if (bv[1] === 1'b1) cap1 = {cap1[30:0], seq[1]};
        if (fs[1] === 1'b1) begin
            fs_prev1 = fs_last1;
            fs_last1 = cyc;
        end
        for (int i = 0; i < N; i++) begin
            m_acc[i] = vld[i] && m_ready(i);
            if (reset !== 1'b1) begin
                m_left[i] = 0;
                m_gap[i]  = 0;
                m_cnt[i]  = 16'd0;
            end else begin
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_cnt[i]++;
                        m_gap[i] = GAP_A[i];
                    end
                end else if (m_gap[i] > 0) begin
                    m_gap[i]--;
                end
                if (m_acc[i]) begin
                    m_word[i] = wd[i];
                    m_left[i] = W_A[i];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int i, input logic [31:0] w, input bit hold);
        int n;
        vld[i] = 1'b1;
        wd[i]  = w;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc[i] && n < 64);
        if (!m_acc[i]) check_val($sformatf("u%0d_xfer_timeout", i), {31'd0, m_acc[i]}, 32'd1);
        if (!hold) vld[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0; wd[i] = 32'd0;
            m_left[i] = 0; m_gap[i] = 0; m_word[i] = 32'd0; m_cnt[i] = 16'd0; m_acc[i] = 1'b0;
        end
        cap0 = 32'd0; cap1 = 32'd0; fs_prev1 = 0; fs_last1 = 0;

        // Reset state
        idle(2);
        check_val("rst_ready_low", {31'd0, rdy[0]}, 32'd0);
        check_val("rst_seq_idle1", {31'd0, seq[1]}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("ready_after_rst", {31'd0, rdy[0]}, 32'd1);
        idle(2);

        // Single MSB-first word
        cap0 = 32'd0;
        send(0, 32'b1011, 1'b0);
        idle(6);
        check_val("t1_bits", cap0, 32'b1011);
        check_val("t1_ws", {16'd0, ws[0]}, 32'd1);

        // Back-to-back words, valid held
        send(0, 32'b1011, 1'b1);
        send(0, 32'b0110, 1'b0);
        idle(8);
        check_val("t2_bits", cap0, 32'b1011_1011_0110);
        check_val("t2_ws", {16'd0, ws[0]}, 32'd3);

        // LSB-first word
        cap1 = 32'd0;
        send(1, 32'b1101, 1'b0);
        idle(8);
        check_val("t3_bits", cap1, 32'b1011);

        // Gap cycles between held words
        send(1, 32'hA, 1'b1);
        send(1, 32'h3, 1'b0);
        idle(10);
        check_val("t4_fs_spacing", fs_last1 - fs_prev1, 32'd7);
        check_val("t4_ws", {16'd0, ws[1]}, 32'd3);

        // Reset after the second bit of a word
        send(0, 32'b1001, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check_val("t5_ready_in_rst", {31'd0, rdy[0]}, 32'd0);
        tick();
        check_val("t5_ws", {16'd0, ws[0]}, 32'd0);
        check_val("t5_bv", {31'd0, bv[0]}, 32'd0);
        check_val("t5_seq", {31'd0, seq[0]}, 32'd0);
        check_val("t5_busy", {31'd0, busy[0]}, 32'd0);
        reset = 1'b1;
        #1;
        check_val("t5_ready_rel", {31'd0, rdy[0]}, 32'd1);
        idle(3);

        // Counter wrap: preload near the top, then send two words
        force u2.words_sent = 16'hFFFE;
        m_cnt[2] = 16'hFFFE;
        #1;
        release u2.words_sent;
        send(2, 32'b10, 1'b1);
        send(2, 32'b01, 1'b0);
        idle(4);
        check_val("t6_wrap", {16'd0, ws[2]}, 32'd0);

        // Randomised traffic with occasional resets
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (m_acc[i] || !vld[i]) begin
                    vld[i] = ($urandom_range(0, 3) != 0);
                    wd[i]  = $urandom;
                end
            end
            reset = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset = 1'b1;
        for (int i = 0; i < N; i++) vld[i] = 1'b0;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Parallel-to-serial stage that sits directly upstream of the team's bit-serial Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on sequence_out. sequence_out wires straight into the detector's sequence_in.
- Provides a framing pulse, a bit-valid qualifier, optional idle gap cycles between words, and a sent-word counter for the bench.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = word_in[WIDTH-1] is sent first; 0 = word_in[0] is sent first.
- GAP_CYCLES, 0, cycles of IDLE_LEVEL inserted after each word; legal range 0..15.
- IDLE_LEVEL, 0, value driven on sequence_out whenever no word bit is being sent.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clock.
- word_in  in  WIDTH  parallel word to serialise.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  feeder accepts word_in this cycle.
- sequence_out  out  1  serial bit stream to the detector.
- bit_valid  out  1  sequence_out carries a word bit (not idle or gap).
- frame_start  out  1  high with the first bit of each word.
- busy  out  1  state is not IDLE.
- words_sent  out  16  count of completely transmitted words; wraps.

Behaviour:
- Reset (reset==0 at rising clock):
  - state=IDLE, sequence_out=IDLE_LEVEL, bit_valid=0, frame_start=0, words_sent=0, bit_cnt=0, gap_cnt=0.
  - word_ready is forced 0 while reset==0.
  - Reset mid-word or mid-gap aborts immediately; the partial word is not counted.
- Handshake:
  - A transfer occurs on a rising edge where word_valid && word_ready.
  - word_ready is combinational from state only, never from word_valid: word_ready = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1 && GAP_CYCLES==0).
  - word_in is sampled only on a transfer edge.
  - word_valid with word_ready low holds off; no data is lost.
- States: IDLE, SHIFT, GAP.
  - IDLE:
    - Outputs: sequence_out=IDLE_LEVEL, bit_valid=0.
    - On transfer: load the shift register, bit_cnt=0, go to SHIFT.
  - SHIFT:
    - Outputs: sequence_out = current bit, bit_valid=1, frame_start=1 only when bit_cnt==0.
    - Each edge: shift toward the send end and increment bit_cnt.
    - When bit_cnt==WIDTH-1, words_sent increments on that edge, then:
      - if GAP_CYCLES>0: go to GAP with gap_cnt=0;
      - else if transfer: reload, bit_cnt=0, stay in SHIFT (zero-bubble back-to-back);
      - else: go to IDLE.
  - GAP:
    - Outputs: sequence_out=IDLE_LEVEL, bit_valid=0, word_ready=0.
    - After GAP_CYCLES cycles, go to IDLE.
- Latency and timing:
  - All outputs except word_ready are registered.
  - For a transfer on edge N, the first bit is visible from edge N to edge N+1. The last bit is visible from edge N+WIDTH-1 to edge N+WIDTH.
  - A word occupies exactly WIDTH clock cycles on sequence_out.
- Throughput:
  - 1 word / WIDTH cycles when GAP_CYCLES=0 and word_valid is held high.
  - Otherwise 1 word / (WIDTH + GAP_CYCLES + 1) cycles, because an IDLE cycle follows the gap.
- Counter: words_sent is an unsigned 16-bit counter; 0xFFFF+1 wraps to 0x0000 with no flag.
- busy = (state != IDLE).
- Out-of-range parameters are unsupported; the implementation must error at elaboration.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, GAP=0; send 4'b1011 once.
   -> sequence_out = 1,0,1,1 on cycles N+1..N+4 (first bit visible from edge N).
   -> bit_valid high for those 4 cycles; frame_start high only on the first.
   -> words_sent=1; then IDLE with sequence_out=0. A downstream detector asserts its output on the following cycle.
2. WIDTH=4, GAP=0; word_valid held high with words 4'b1011 then 4'b0110.
   -> 8 contiguous bit_valid cycles: 1,0,1,1,0,1,1,0.
   -> word_ready high on the 4th bit; frame_start pulses twice, 4 cycles apart; words_sent=2.
3. WIDTH=4, MSB_FIRST=0; send 4'b1101.
   -> sequence_out = 1,0,1,1.
4. WIDTH=4, GAP_CYCLES=2, IDLE_LEVEL=1; word_valid held with two words.
   -> After each word: 2 gap cycles plus 1 IDLE cycle with sequence_out=1 and bit_valid=0.
   -> Second frame_start occurs 7 cycles after the first.
5. Drive reset=0 for one edge after the 2nd bit of a word.
   -> Next cycle: state IDLE, sequence_out=IDLE_LEVEL, bit_valid=0, words_sent=0.
   -> word_ready=0 during reset low and 1 after release.
6. Preload via 65535 back-to-back words of WIDTH=2, then send one more.
   -> words_sent goes 0xFFFF -> 0x0000.
